// File: rtl/iir_sos_tdm_pkg.sv
// Shared formats, coefficient indices, FSM states and
// fixed-point helpers for the time-multiplexed biquad cascade.
package iir_pkg;

  localparam int WIX_D  = 3;
  localparam int WFX_D  = 7;
  localparam int WIC_D  = 2;
  localparam int WFC_D  = 8;
  localparam int WIS_D  = 5;
  localparam int WFS_D  = 11;
  localparam int WIO_D  = 14;
  localparam int WFO_D  = 24;
  localparam int NSEC_D = 4;

  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A0 = 3;
  localparam int A1 = 4;
  localparam int A2 = 5;
  localparam int NK = 6;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WB,
    DONE
  } state_t;

  // MAC tap order: b0*x, b1*x1, b2*x2, a1*y1, a2*y2
  function automatic int coef_idx(input logic [2:0] tap);
    unique case (tap)
      3'd0:    return B0;
      3'd1:    return B1;
      3'd2:    return B2;
      3'd3:    return A1;
      3'd4:    return A2;
      default: return A0;
    endcase
  endfunction

  function automatic logic signed [63:0] rnd_hu(
    input logic signed [63:0] v,
    input int                 sh
  );
    if (sh <= 0) return v;
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/iir_sos_tdm_if.sv
// Sample, coefficient and result bundle of the biquad cascade.
// The source/host side is master, the filter is slave.
interface iir_sos_tdm_if
  import iir_pkg::*;
#(
  parameter int WIX  = WIX_D,
  parameter int WFX  = WFX_D,
  parameter int WIC  = WIC_D,
  parameter int WFC  = WFC_D,
  parameter int WIO  = WIO_D,
  parameter int WFO  = WFO_D,
  parameter int NSEC = NSEC_D
);
  localparam int AW = $clog2(NK * NSEC);

  logic signed [WIX+WFX-1:0] X;
  logic                      CE;
  logic                      READY;
  logic                      COEF_WE;
  logic        [AW-1:0]      COEF_ADDR;
  logic signed [WIC+WFC-1:0] COEF_DATA;
  logic signed [WIO+WFO-1:0] Y;
  logic                      Y_VALID;
  logic                      overflow;

  modport master (
    output X, CE, COEF_WE, COEF_ADDR, COEF_DATA,
    input  READY, Y, Y_VALID, overflow
  );

  modport slave (
    input  X, CE, COEF_WE, COEF_ADDR, COEF_DATA,
    output READY, Y, Y_VALID, overflow
  );

endinterface

// File: rtl/iir_sos_tdm_mac_sat.sv
// Shared signed MAC: full-precision accumulator, then
// round-half-up and saturation of the section result.
module iir_mac_sat
  import iir_pkg::*;
#(
  parameter int WIS = WIS_D,
  parameter int WFS = WFS_D,
  parameter int WIC = WIC_D,
  parameter int WFC = WFC_D
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      en,
  input  logic                      first,
  input  logic                      neg,
  input  logic signed [WIS+WFS-1:0] a,
  input  logic signed [WIC+WFC-1:0] c,
  output logic signed [WIS+WFS-1:0] y,
  output logic                      clip
);
  localparam int WS = WIS + WFS;
  localparam int WA = WS + WIC + WFC + 3;

  logic signed [WA-1:0] acc;
  logic signed [WA-1:0] nxt;
  logic signed [WA-1:0] ae;
  logic signed [WA-1:0] ce;
  logic signed [WA-1:0] p;
  logic signed [63:0]   r;
  logic signed [63:0]   s;

  assign ae = WA'(a);
  assign ce = WA'(c);
  assign p  = ae * ce;

  always_comb begin
    nxt = first ? '0 : acc;
    nxt = neg ? nxt - p : nxt + p;
  end

  always_ff @(posedge CLK) begin
    if (!RESET)  acc <= '0;
    else if (en) acc <= nxt;
  end

  always_comb begin
    r    = rnd_hu(64'(acc), WFC);
    s    = sat(r, WS);
    clip = (s != r);
    y    = s[WS-1:0];
  end

endmodule

// File: rtl/iir_sos_tdm.sv
// Cascaded direct-form-I biquads sharing one MAC; coefficient
// RAM, per-section delay lines and the sequencing FSM live here.
module iir_sos_tdm
  import iir_pkg::*;
#(
  parameter int WIX  = WIX_D,
  parameter int WFX  = WFX_D,
  parameter int WIC  = WIC_D,
  parameter int WFC  = WFC_D,
  parameter int WIS  = WIS_D,
  parameter int WFS  = WFS_D,
  parameter int WIO  = WIO_D,
  parameter int WFO  = WFO_D,
  parameter int NSEC = NSEC_D
) (
  input logic          CLK,
  input logic          RESET,
  iir_sos_tdm_if.slave bus
);
  localparam int WS = WIS + WFS;
  localparam int WO = WIO + WFO;
  localparam int NC = NK * NSEC;
  localparam int AW = $clog2(NC);
  localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam logic [SW-1:0] LAST = SW'(NSEC - 1);

  state_t                    st;
  logic [SW-1:0]             sec;
  logic [2:0]                tap;
  logic [AW-1:0]             caddr;
  logic signed [WIC+WFC-1:0] cram [NC];
  logic signed [WS-1:0]      x1 [NSEC];
  logic signed [WS-1:0]      x2 [NSEC];
  logic signed [WS-1:0]      y1 [NSEC];
  logic signed [WS-1:0]      y2 [NSEC];
  logic signed [WS-1:0]      xs;
  logic signed [WS-1:0]      opnd;
  logic signed [WS-1:0]      ysec;
  logic                      clip;

  assign caddr = AW'(int'(sec) * NK + coef_idx(tap));

  always_comb begin
    opnd = xs;
    unique case (tap)
      3'd1:    opnd = x1[sec];
      3'd2:    opnd = x2[sec];
      3'd3:    opnd = y1[sec];
      3'd4:    opnd = y2[sec];
      default: opnd = xs;
    endcase
  end

  iir_mac_sat #(
    .WIS(WIS),
    .WFS(WFS),
    .WIC(WIC),
    .WFC(WFC)
  ) u_mac (
    .CLK  (CLK),
    .RESET(RESET),
    .en   (st == MAC),
    .first(tap == 3'd0),
    .neg  (tap >= 3'd3),
    .a    (opnd),
    .c    (cram[caddr]),
    .y    (ysec),
    .clip (clip)
  );

  // RAM keeps its contents through reset
  always_ff @(posedge CLK) begin
    if (RESET && st == IDLE && bus.COEF_WE &&
        int'(bus.COEF_ADDR) < NC)
      cram[bus.COEF_ADDR] <= bus.COEF_DATA;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      st           <= IDLE;
      sec          <= '0;
      tap          <= '0;
      xs           <= '0;
      bus.READY    <= 1'b1;
      bus.Y        <= '0;
      bus.Y_VALID  <= 1'b0;
      bus.overflow <= 1'b0;
      for (int i = 0; i < NSEC; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      bus.Y_VALID <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.CE) begin
            xs        <= WS'(bus.X) <<< (WFS - WFX);
            sec       <= '0;
            tap       <= '0;
            bus.READY <= 1'b0;
            st        <= MAC;
          end
        end
        MAC: begin
          if (tap == 3'd4) st <= WB;
          else             tap <= tap + 3'd1;
        end
        WB: begin
          x2[sec] <= x1[sec];
          x1[sec] <= xs;
          y2[sec] <= y1[sec];
          y1[sec] <= ysec;
          xs      <= ysec;
          tap     <= '0;
          if (clip) bus.overflow <= 1'b1;
          if (sec == LAST) begin
            st <= DONE;
          end else begin
            sec <= sec + SW'(1);
            st  <= MAC;
          end
        end
        DONE: begin
          bus.Y       <= WO'(xs) <<< (WFO - WFS);
          bus.Y_VALID <= 1'b1;
          bus.READY   <= 1'b1;
          st          <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_sos_tdm.sv
// Directed bench for the 4-section biquad cascade: gain,
// latency, recursion, rounding, saturation, handshake, aborts.
module tb_iir_sos_tdm;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   total = 0;
  int   bad   = 0;

  localparam logic [37:0] Y_ZERO = 38'h0000000000;
  localparam logic [37:0] Y_HALF = 38'h0000800000;
  localparam logic [37:0] Y_NHLF = 38'h3FFF800000;
  localparam logic [37:0] Y_ONE  = 38'h0001000000;
  localparam logic [37:0] Y_QTR  = 38'h0000400000;
  localparam logic [37:0] Y_EGH  = 38'h0000200000;
  localparam logic [37:0] Y_SAT  = 38'h000FFFE000;
  localparam logic [37:0] Y_NSAT = 38'h3FF0000000;
  localparam logic [37:0] Y_S1   = 38'h000FE00000;
  localparam logic [37:0] Y_LSB  = 38'h0000002000;

  iir_sos_tdm_if bus ();

  iir_sos_tdm dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wcoef(input int a, input logic [9:0] d);
    bus.COEF_WE   = 1'b1;
    bus.COEF_ADDR = 5'(a);
    bus.COEF_DATA = d;
    tick();
    bus.COEF_WE   = 1'b0;
  endtask

  task automatic load_b0(input logic [9:0] bf, input logic [9:0] br);
    for (int i = 0; i < 24; i++) wcoef(i, 10'h000);
    wcoef(0, bf);
    for (int s = 1; s < 4; s++) wcoef(6 * s, br);
  endtask

  task automatic load_rec;
    load_b0(10'h100, 10'h100);
    wcoef(3, 10'h3FF);
    wcoef(4, 10'h380);
    wcoef(24, 10'h1FF);
  endtask

  task automatic do_reset;
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  task automatic wait_y(output logic [37:0] y, output int lat);
    lat = 0;
    while (lat < 200) begin
      tick();
      lat++;
      if (bus.Y_VALID) break;
    end
    if (!bus.Y_VALID) lat = -1;
    y = bus.Y;
  endtask

  task automatic send(input logic [9:0] x, output logic [37:0] y, output int lat);
    int n;
    n = 0;
    while (!bus.READY && n < 100) begin
      tick();
      n++;
    end
    bus.X  = x;
    bus.CE = 1'b1;
    tick();
    bus.CE = 1'b0;
    wait_y(y, lat);
  endtask

  task automatic test_reset;
    logic [37:0] y;
    int          lat;
    load_b0(10'h1FF, 10'h1FF);
    send(10'h1FF, y, lat);
    do_reset();
    total++;
    if (bus.Y !== Y_ZERO) begin
      bad++;
      $display("FAIL reset_y: got %h want %h", bus.Y, Y_ZERO);
    end
    total++;
    if (bus.Y_VALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_yvalid: got %b want 0", bus.Y_VALID);
    end
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf: got %b want 0", bus.overflow);
    end
    total++;
    if (bus.READY !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", bus.READY);
    end
    send(10'h080, y, lat);
    total++;
    if (y !== Y_S1) begin
      bad++;
      $display("FAIL reset_coef_kept: got %h want %h", y, Y_S1);
    end
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_coef_ovf: got %b want 0", bus.overflow);
    end
  endtask

  task automatic test_gain;
    logic [37:0] y;
    int          lat;
    do_reset();
    load_b0(10'h080, 10'h100);
    send(10'h080, y, lat);
    total++;
    if (y !== Y_HALF) begin
      bad++;
      $display("FAIL gain_pos: got %h want %h", y, Y_HALF);
    end
    total++;
    if (lat !== 25) begin
      bad++;
      $display("FAIL gain_latency: got %0d want 25", lat);
    end
    send(10'h380, y, lat);
    total++;
    if (y !== Y_NHLF) begin
      bad++;
      $display("FAIL gain_neg: got %h want %h", y, Y_NHLF);
    end
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL gain_ovf: got %b want 0", bus.overflow);
    end
  endtask

  task automatic test_rounding;
    logic [37:0] y;
    int          lat;
    do_reset();
    load_b0(10'h008, 10'h100);
    send(10'h001, y, lat);
    total++;
    if (y !== Y_LSB) begin
      bad++;
      $display("FAIL round_half_pos: got %h want %h", y, Y_LSB);
    end
    send(10'h3FF, y, lat);
    total++;
    if (y !== Y_ZERO) begin
      bad++;
      $display("FAIL round_half_neg: got %h want %h", y, Y_ZERO);
    end
  endtask

  task automatic test_recursion;
    logic [37:0] y;
    logic [37:0] exp_y [4];
    logic [9:0]  xin [4];
    int          lat;
    exp_y = '{Y_ONE, Y_HALF, Y_QTR, Y_EGH};
    xin   = '{10'h080, 10'h000, 10'h000, 10'h000};
    do_reset();
    load_rec();
    for (int i = 0; i < 4; i++) begin
      send(xin[i], y, lat);
      total++;
      if (y !== exp_y[i]) begin
        bad++;
        $display("FAIL recursion_%0d: got %h want %h", i, y, exp_y[i]);
      end
    end
  endtask

  task automatic test_saturation;
    logic [37:0] y;
    int          lat;
    do_reset();
    load_b0(10'h1FF, 10'h1FF);
    send(10'h1FF, y, lat);
    total++;
    if (y !== Y_SAT) begin
      bad++;
      $display("FAIL sat_pos: got %h want %h", y, Y_SAT);
    end
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL sat_ovf_set: got %b want 1", bus.overflow);
    end
    send(10'h200, y, lat);
    total++;
    if (y !== Y_NSAT) begin
      bad++;
      $display("FAIL sat_neg: got %h want %h", y, Y_NSAT);
    end
    load_b0(10'h080, 10'h100);
    send(10'h080, y, lat);
    total++;
    if (y !== Y_HALF) begin
      bad++;
      $display("FAIL sat_after: got %h want %h", y, Y_HALF);
    end
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL sat_ovf_sticky: got %b want 1", bus.overflow);
    end
  endtask

  task automatic test_handshake;
    int tv [4];
    int np;
    do_reset();
    load_b0(10'h080, 10'h100);
    np     = 0;
    bus.X  = 10'h080;
    bus.CE = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (bus.Y_VALID) begin
        if (np < 4) tv[np] = i;
        np++;
      end
    end
    bus.CE = 1'b0;
    total++;
    if (np !== 3) begin
      bad++;
      $display("FAIL hs_count: got %0d want 3", np);
    end else begin
      total++;
      if (tv[0] !== 26) begin
        bad++;
        $display("FAIL hs_first: got %0d want 26", tv[0]);
      end
      total++;
      if (tv[1] - tv[0] !== 26 || tv[2] - tv[1] !== 26) begin
        bad++;
        $display("FAIL hs_period: got %0d,%0d want 26", tv[1] - tv[0], tv[2] - tv[1]);
      end
    end
    np = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Y_VALID) np++;
    end
    total++;
    if (np !== 1) begin
      bad++;
      $display("FAIL hs_drain: got %0d want 1", np);
    end
    np     = 0;
    bus.CE = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.CE = (i % 3 == 0);
      tick();
      if (bus.Y_VALID) np++;
    end
    bus.CE = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.Y_VALID) np++;
    end
    total++;
    if (np !== 1) begin
      bad++;
      $display("FAIL hs_busy_ce: got %0d pulses want 1", np);
    end
  endtask

  task automatic test_midop;
    logic [37:0] y;
    int          lat;
    int          np;
    do_reset();
    load_b0(10'h080, 10'h100);
    bus.X  = 10'h080;
    bus.CE = 1'b1;
    tick();
    bus.CE        = 1'b0;
    bus.COEF_WE   = 1'b1;
    bus.COEF_ADDR = 5'd0;
    bus.COEF_DATA = 10'h100;
    for (int i = 0; i < 10; i++) tick();
    bus.COEF_WE = 1'b0;
    wait_y(y, lat);
    total++;
    if (y !== Y_HALF) begin
      bad++;
      $display("FAIL busy_we_cur: got %h want %h", y, Y_HALF);
    end
    send(10'h080, y, lat);
    total++;
    if (y !== Y_HALF) begin
      bad++;
      $display("FAIL busy_we_next: got %h want %h", y, Y_HALF);
    end
    bus.COEF_WE   = 1'b1;
    bus.COEF_ADDR = 5'd0;
    bus.COEF_DATA = 10'h100;
    bus.X         = 10'h080;
    bus.CE        = 1'b1;
    tick();
    bus.COEF_WE = 1'b0;
    bus.CE      = 1'b0;
    wait_y(y, lat);
    total++;
    if (y !== Y_ONE) begin
      bad++;
      $display("FAIL we_with_ce: got %h want %h", y, Y_ONE);
    end
    do_reset();
    load_rec();
    send(10'h080, y, lat);
    bus.X  = 10'h000;
    bus.CE = 1'b1;
    tick();
    bus.CE = 1'b0;
    tick();
    tick();
    tick();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    np    = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Y_VALID) np++;
    end
    total++;
    if (np !== 0) begin
      bad++;
      $display("FAIL abort_no_valid: got %0d pulses want 0", np);
    end
    send(10'h080, y, lat);
    total++;
    if (y !== Y_ONE) begin
      bad++;
      $display("FAIL abort_restart: got %h want %h", y, Y_ONE);
    end
    send(10'h000, y, lat);
    total++;
    if (y !== Y_HALF) begin
      bad++;
      $display("FAIL abort_tail: got %h want %h", y, Y_HALF);
    end
  endtask

  initial begin
    bus.X         = '0;
    bus.CE        = 1'b0;
    bus.COEF_WE   = 1'b0;
    bus.COEF_ADDR = '0;
    bus.COEF_DATA = '0;
    do_reset();
    test_reset();
    test_gain();
    test_rounding();
    test_recursion();
    test_saturation();
    test_handshake();
    test_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
